// File: rtl/shr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : shr_pkg
//  Description : Shared constants and state encoding for the serial
//                shift-register link receiver (shr_frame_rx).
//                Optional feature macro used by the receiver: SHR_RX_CMP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package shr_pkg;

    localparam int SHR_MAX_BITS = 1024;  // default capture depth
    localparam int SHR_SEQ_W    = 10;    // width of the expected-length input

    // Receiver state encoding
    localparam logic [1:0] SHR_ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] SHR_ST_IDLE      = 2'd1;
    localparam logic [1:0] SHR_ST_RECV      = 2'd2;
    localparam logic [1:0] SHR_ST_DONE      = 2'd3;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = SHR_ST_WAIT_IDLE,
        ST_IDLE      = SHR_ST_IDLE,
        ST_RECV      = SHR_ST_RECV,
        ST_DONE      = SHR_ST_DONE
    } shr_state_e;

endpackage : shr_pkg
`default_nettype wire

// File: rtl/shr_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : shr_edge_sync
//  Description : Multi-flop synchronizer for one asynchronous input followed
//                by a single edge-detect flop. Level and edge outputs are
//                time-aligned so several instances see matched delay.
//  Ports       : clk_i    - sample clock
//                rst_ni   - asynchronous active-low reset (clears all flops)
//                async_i  - asynchronous input
//                level_o  - synchronized level
//                rise_o   - one-cycle pulse on a 0->1 transition of level_o
//                fall_o   - one-cycle pulse on a 1->0 transition of level_o
//  Revision    : 1.0  initial release
// ============================================================================
module shr_edge_sync #(
    parameter int STAGES = 2            // synchronizer depth, >= 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule : shr_edge_sync
`default_nettype wire

// File: rtl/shr_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : shr_frame_rx
//  Description : Receive end of the DIN/CLK/SYNC serial shift-register link.
//                Oversamples the link on clk_in, captures each SYNC-framed
//                (s_syn low) bit sequence into rx_data (bit k -> rx_data[k]),
//                and reports bit count, length error and overflow.
//  Ports       : clk_in      - local sample clock (>= 4x link CLK)
//                rst_n       - asynchronous active-low reset
//                s_clk       - link CLK, data taken on its rising edge
//                s_din       - link DIN
//                s_syn       - link SYNC, active low
//                seq_length  - expected frame length (0 disables check)
//                rx_data     - captured bits
//                rx_count    - bit count of last frame, saturates MAX_BITS+1
//                frame_done  - one-cycle pulse when a frame closes
//                len_err     - last frame length mismatch
//                ovf         - last frame longer than MAX_BITS
//                busy        - frame reception in progress
//                exp_data    - expected frame bits   (SHR_RX_CMP_EN only)
//                cmp_err     - captured != expected  (SHR_RX_CMP_EN only)
//  Options     : define SHR_RX_CMP_EN to add the data compare.
//  Revision    : 1.0  initial release
// ============================================================================
module shr_frame_rx
    import shr_pkg::*;
#(
    parameter int MAX_BITS    = SHR_MAX_BITS,
    parameter int CNT_W       = 11,   // must hold MAX_BITS+1
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 s_clk,
    input  logic                 s_din,
    input  logic                 s_syn,
    input  logic [SHR_SEQ_W-1:0] seq_length,
`ifdef SHR_RX_CMP_EN
    input  logic [MAX_BITS-1:0]  exp_data,
    output logic                 cmp_err,
`endif
    output logic [MAX_BITS-1:0]  rx_data,
    output logic [CNT_W-1:0]     rx_count,
    output logic                 frame_done,
    output logic                 len_err,
    output logic                 ovf,
    output logic                 busy
);

    localparam int               IDX_W   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int               LCMP_W  = (CNT_W > SHR_SEQ_W) ? CNT_W : SHR_SEQ_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BITS + 1);

    // ------------------------------------------------------------------
    // Input synchronization (all three inputs share the same delay)
    // ------------------------------------------------------------------
    logic clk_rise;
    logic clk_unused_lvl, clk_unused_fall;
    logic din_lvl;
    logic din_unused_rise, din_unused_fall;
    logic syn_lvl, syn_rise, syn_fall;

    shr_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk_i   (clk_in),
        .rst_ni  (rst_n),
        .async_i (s_clk),
        .level_o (clk_unused_lvl),
        .rise_o  (clk_rise),
        .fall_o  (clk_unused_fall)
    );

    shr_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk_i   (clk_in),
        .rst_ni  (rst_n),
        .async_i (s_din),
        .level_o (din_lvl),
        .rise_o  (din_unused_rise),
        .fall_o  (din_unused_fall)
    );

    shr_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_syn (
        .clk_i   (clk_in),
        .rst_ni  (rst_n),
        .async_i (s_syn),
        .level_o (syn_lvl),
        .rise_o  (syn_rise),
        .fall_o  (syn_fall)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    shr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;   // s_syn fall seen while in DONE
    logic             capture;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = 1'b0;
        capture    = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: begin
                // Never join a frame that was already running at reset.
                if (syn_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (syn_fall || pend_q) begin
                    state_d = ST_RECV;
                    cnt_d   = '0;
                end
            end
            ST_RECV: begin
                busy = 1'b1;
                // A bit arriving together with the closing edge is still
                // stored; the count seen in DONE includes it.
                if (clk_rise) begin
                    if (cnt_q < CNT_MAX) begin
                        capture = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d   = CNT_SAT;
                    end
                end
                if (syn_rise) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                pend_d     = syn_fall;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture register and frame status
    // ------------------------------------------------------------------
    logic [MAX_BITS-1:0] rx_data_q;
    logic [CNT_W-1:0]    rx_count_q;
    logic                len_err_q, ovf_q;
    logic                len_err_d;

    assign len_err_d = (seq_length != '0) &&
                       (LCMP_W'(cnt_q) != LCMP_W'(seq_length));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_count_q <= '0;
            len_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (capture) begin
                rx_data_q[cnt_q[IDX_W-1:0]] <= din_lvl;
            end
            if (frame_done) begin
                rx_count_q <= cnt_q;
                len_err_q  <= len_err_d;
                ovf_q      <= (cnt_q > CNT_MAX);
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_count = rx_count_q;
    assign len_err  = len_err_q;
    assign ovf      = ovf_q;

`ifdef SHR_RX_CMP_EN
    // Only bit positions below the final count take part in the compare.
    logic [MAX_BITS-1:0] cmp_mask;
    logic                cmp_err_q;

    always_comb begin
        cmp_mask = '0;
        for (int k = 0; k < MAX_BITS; k++) begin
            cmp_mask[k] = (CNT_W'(k) < cnt_q);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cmp_err_q <= 1'b0;
        end else if (frame_done) begin
            cmp_err_q <= |((rx_data_q ^ exp_data) & cmp_mask);
        end
    end

    assign cmp_err = cmp_err_q;
`endif

endmodule : shr_frame_rx
`default_nettype wire

// File: tb/tb_shr_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shr_frame_rx
//  Description : Self-checking bench for shr_frame_rx (16-bit capture depth).
//                Directed frames plus randomized frames, each compared with a
//                frame-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shr_frame_rx;

    localparam int MB = 16;
    localparam int CW = 5;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          s_clk  = 1'b0;
    logic          s_din  = 1'b0;
    logic          s_syn  = 1'b1;
    logic [9:0]    seq_length = '0;
    logic [MB-1:0] rx_data;
    logic [CW-1:0] rx_count;
    logic          frame_done, len_err, ovf, busy;
`ifdef SHR_RX_CMP_EN
    logic [MB-1:0] exp_data = '0;
    logic          cmp_err;
`endif

    shr_frame_rx #(.MAX_BITS(MB), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .s_clk      (s_clk),
        .s_din      (s_din),
        .s_syn      (s_syn),
        .seq_length (seq_length),
`ifdef SHR_RX_CMP_EN
        .exp_data   (exp_data),
        .cmp_err    (cmp_err),
`endif
        .rx_data    (rx_data),
        .rx_count   (rx_count),
        .frame_done (frame_done),
        .len_err    (len_err),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_total    = 0;
    int n_bad      = 0;
    int done_seen  = 0;

    // Count frame_done samples away from the active edge.
    always @(negedge clk_in) begin
        if (frame_done) done_seen++;
    end

    // Reference model state
    logic [MB-1:0] m_data  = '0;
    int            m_count = 0;
    logic          m_len   = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_cmp   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".rx_count"}, 64'(rx_count), 64'(m_count));
        check({tag, ".rx_data"},  64'(rx_data),  64'(m_data));
        check({tag, ".len_err"},  64'(len_err),  64'(m_len));
        check({tag, ".ovf"},      64'(ovf),      64'(m_ovf));
        check({tag, ".busy"},     64'(busy),     64'd0);
`ifdef SHR_RX_CMP_EN
        check({tag, ".cmp_err"},  64'(cmp_err),  64'(m_cmp));
`endif
    endtask

    // Frame-level model: what the receiver should report for a frame of
    // nbits bits taken from bits[], given the current seq_length.
    task automatic model_frame(input int nbits, input logic [31:0] bits);
        logic [MB-1:0] mask;
        for (int k = 0; k < nbits && k < MB; k++) m_data[k] = bits[k];
        m_count = (nbits > MB) ? MB + 1 : nbits;
        m_len   = (seq_length != 0) && (m_count != int'(seq_length));
        m_ovf   = (nbits > MB);
        mask    = '0;
        for (int k = 0; k < MB; k++) mask[k] = (k < m_count);
`ifdef SHR_RX_CMP_EN
        m_cmp   = |((m_data ^ exp_data) & mask);
`else
        m_cmp   = |(mask & ~mask);
`endif
    endtask

    task automatic send_frame(input string tag, input int nbits, input logic [31:0] bits,
                              input bit coincide);
        int d0;
        d0 = done_seen;
        s_syn = 1'b0;
        wait_clk(4);
        check({tag, ".busy_recv"}, 64'(busy), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            s_clk = 1'b0;
            s_din = bits[i];
            wait_clk(3);
            s_clk = 1'b1;
            if (coincide && i == nbits - 1) s_syn = 1'b1;
            wait_clk(3);
        end
        s_clk = 1'b0;
        if (!(coincide && nbits > 0)) begin
            wait_clk(3);
            s_syn = 1'b1;
        end
        for (int t = 0; t < 30 && done_seen == d0; t++) wait_clk(1);
        wait_clk(4);
        model_frame(nbits, bits);
        check({tag, ".done_pulses"}, 64'(done_seen - d0), 64'd1);
        check_status(tag);
    endtask

    initial begin
        // Reset with s_syn high
        wait_clk(3);
        check_status("reset");
        check("reset.frame_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;
        wait_clk(10);

        // 8-bit 0xA5 LSB-first
        seq_length = 10'd8;
        send_frame("a5", 8, 32'hA5, 1'b0);

        // Length mismatch then match
        seq_length = 10'd10;
        send_frame("len12", 12, 32'hB3C, 1'b0);
        send_frame("len10", 10, 32'h2F1, 1'b0);

        // Overflow: 20 bits into 16-bit capture
        seq_length = 10'd0;
        send_frame("ovf20", 20, 32'hF1234, 1'b0);

        // Zero-bit frame
        seq_length = 10'd8;
        send_frame("zero", 0, 32'h0, 1'b0);

        // Last s_clk rise coincident with s_syn rise
        seq_length = 10'd6;
        send_frame("coinc", 6, 32'h2D, 1'b1);

        // Reset in mid-frame, released while s_syn still low
        begin
            int d0;
            d0 = done_seen;
            s_syn = 1'b0;
            wait_clk(4);
            for (int i = 0; i < 5; i++) begin
                s_clk = 1'b0; s_din = i[0]; wait_clk(3);
                s_clk = 1'b1;               wait_clk(3);
            end
            s_clk = 1'b0;
            rst_n = 1'b0;
            wait_clk(2);
            m_data = '0; m_count = 0; m_len = 1'b0; m_ovf = 1'b0; m_cmp = 1'b0;
            check_status("midrst");
            rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                s_clk = 1'b0; s_din = 1'b1; wait_clk(3);
                s_clk = 1'b1;               wait_clk(3);
            end
            s_clk = 1'b0;
            wait_clk(3);
            s_syn = 1'b1;
            wait_clk(15);
            check("midrst.no_done", 64'(done_seen - d0), 64'd0);
            check_status("midrst.after");
            seq_length = 10'd9;
            send_frame("postrst", 9, 32'h1C7, 1'b0);
        end

`ifdef SHR_RX_CMP_EN
        seq_length = 10'd16;
        exp_data   = 16'h00FF;
        send_frame("cmp_bad", 16, 32'h00FE, 1'b0);
        send_frame("cmp_ok",  16, 32'h00FF, 1'b0);
`endif

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            int          n;
            int          sel;
            logic [31:0] b;
            bit          co;
            n   = int'($urandom_range(0, 20));
            b   = $urandom;
            co  = (n > 0) && ($urandom_range(0, 1) == 1);
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      seq_length = 10'd0;
            else if (sel == 1) seq_length = 10'(n);
            else               seq_length = 10'($urandom_range(1, 20));
`ifdef SHR_RX_CMP_EN
            exp_data = ($urandom_range(0, 1) == 1) ? b[MB-1:0] : MB'($urandom);
`endif
            send_frame($sformatf("rnd%0d", r), n, b, co);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_shr_frame_rx
`default_nettype wire
